mem_dma_master: RTL and testbench

- Bus initiator for the MU0 memory interface (memrq/rnw/addr/data with shared bidirectional data).
- Performs block copy (memory to memory) or block fill (constant to memory) without processor involvement.
- Sits beside the MU0 core on the same memory bus. Arbitration is by a simple bus_req/bus_gnt handshake with the system arbiter.
- Tests and loaders use it to move program images and data tables inside the 4K-word memory.

---
 rtl/mem_dma_master_pkg.sv | 19 +
 rtl/mem_dma_master_addr_gen.sv | 47 ++++
 rtl/mem_dma_master.sv | 135 +++++++++++++
 tb/tb_mem_dma_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_master_pkg.sv
// Shared constants for the MU0-bus DMA master: bus widths, transfer modes and FSM encodings.
package mem_dma_master_pkg;

    localparam int DMA_AW = 12;
    localparam int DMA_DW = 16;
    localparam int DMA_LW = 13;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } dma_state_e;

endpackage

// File: rtl/mem_dma_master_addr_gen.sv
// Base/index bookkeeping for the DMA master: wrapped source and destination
// addresses plus the last-word compare.
module mem_dma_addr_gen
    import mem_dma_master_pkg::*;
#(
    parameter int AW = DMA_AW,
    parameter int LW = DMA_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          last_o
);

    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            src_q <= src_i;
            dst_q <= dst_i;
            len_q <= len_i;
            idx_q <= '0;
        end else if (step_i) begin
            idx_q <= idx_q + LW'(1);
        end
    end

    // AW-bit sums wrap naturally at the top of memory
    assign rd_addr_o = src_q + idx_q[AW-1:0];
    assign wr_addr_o = dst_q + idx_q[AW-1:0];
    assign last_o    = (idx_q + LW'(1)) == len_q;

endmodule

// File: rtl/mem_dma_master.sv
// Block copy / block fill bus initiator for the MU0 memory interface.
// state | meaning
// IDLE  | waiting for start
// ARB   | bus_req high, waiting for first grant
// READ  | copy: fetch source word into wbuf
// WRITE | store wbuf or fill constant to destination
// FIN   | one-cycle done pulse
module mem_dma_master
    import mem_dma_master_pkg::*;
#(
    parameter int AW = DMA_AW,
    parameter int DW = DMA_DW,
    parameter int LW = DMA_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_data,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic          memrq,
    output logic          rnw,
    output logic [AW-1:0] addr,
    inout  wire  [DW-1:0] data,
    output logic          busy,
    output logic          done
);

    dma_state_e    state_q;
    logic          mode_q;
    logic [DW-1:0] fill_q;
    logic [DW-1:0] wbuf_q;
    logic          busy_q;
    logic          done_q;
    logic          bus_req_q;

    logic          accept;
    logic          rd_cyc;
    logic          wr_cyc;
    logic          last;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    assign accept = (state_q == ST_IDLE) && start;
    assign rd_cyc = (state_q == ST_READ) && bus_gnt;
    assign wr_cyc = (state_q == ST_WRITE) && bus_gnt;

    mem_dma_addr_gen #(
        .AW(AW),
        .LW(LW)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .step_i    (wr_cyc),
        .src_i     (src_addr),
        .dst_i     (dst_addr),
        .len_i     (len),
        .rd_addr_o (rd_addr),
        .wr_addr_o (wr_addr),
        .last_o    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COPY;
            fill_q    <= '0;
            wbuf_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        fill_q <= fill_data;
                        if (len == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_ARB;
                            busy_q    <= 1'b1;
                            bus_req_q <= 1'b1;
                        end
                    end
                end
                ST_ARB: begin
                    if (bus_gnt) begin
                        state_q <= (mode_q == MODE_FILL) ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (bus_gnt) begin
                        wbuf_q  <= data;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus_gnt) begin
                        if (last) begin
                            state_q   <= ST_FIN;
                            busy_q    <= 1'b0;
                            bus_req_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (mode_q == MODE_COPY) begin
                            state_q <= ST_READ;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus strobes follow grant within the cycle so a dropped grant never leaves a stray access
    assign memrq   = rd_cyc || wr_cyc;
    assign rnw     = !wr_cyc;
    assign addr    = (state_q == ST_READ)  ? rd_addr :
                     (state_q == ST_WRITE) ? wr_addr : '0;
    assign data    = wr_cyc ? ((mode_q == MODE_FILL) ? fill_q : wbuf_q) : 'z;

    assign busy    = busy_q;
    assign done    = done_q;
    assign bus_req = bus_req_q;

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed bench for mem_dma_master: copy, fill, grant stalls, wrap, len=0,
// start-while-busy and mid-transfer reset against a small MU0 memory model.
module tb_mem_dma_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [12:0] len = '0;
    logic [15:0] fill_data = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic        memrq;
    logic        rnw;
    logic [11:0] addr;
    tri1  [15:0] data;
    logic        busy;
    logic        done;

    logic [15:0] mem [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          req_cnt = 0;
    logic [11:0] rd_log [$];
    int          wr_cyc_log [$];
    int          t0;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_dma_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .memrq     (memrq),
        .rnw       (rnw),
        .addr      (addr),
        .data      (data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // responder: combinational read data, writes committed on the falling edge
    assign data = (memrq && rnw) ? mem[addr] : 16'bz;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memrq && !rnw) begin
            mem[addr] = data;
            wr_cyc_log.push_back(cyc);
        end else if (pl_en) begin
            mem[pl_addr] = pl_data;
        end
        if (memrq && rnw) rd_log.push_back(addr);
        if (done) done_cnt = done_cnt + 1;
        if (bus_req) req_cnt = req_cnt + 1;
    end

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1 pl_en = 1'b0;
    endtask

    // leaves the bench 1 time unit after the edge that accepted start
    task automatic kick(input logic m, input logic [11:0] s, input logic [11:0] d,
                        input logic [12:0] l, input logic [15:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                n = cyc - t0 + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({busy, done, bus_req, memrq, rnw} !== 5'b00001) begin
            n_bad++; $display("FAIL reset_ctl got %b want 00001", {busy, done, bus_req, memrq, rnw});
        end
        n_cmp++; if (addr !== 12'h000) begin
            n_bad++; $display("FAIL reset_addr got %h want 000", addr);
        end
        n_cmp++; if (data !== 16'hFFFF) begin
            n_bad++; $display("FAIL reset_data_released got %h want FFFF", data);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_copy;
        int n;
        logic [15:0] exp [3];
        exp[0] = 16'h4444; exp[1] = 16'h2222; exp[2] = 16'h1111;
        for (int k = 0; k < 3; k++) preload(12'h064 + 12'(k), exp[k]);
        preload(12'h203, 16'h7777);
        kick(1'b0, 12'h064, 12'h200, 13'd3, 16'h0000);
        wait_done(n);
        n_cmp++; if (n !== 8) begin
            n_bad++; $display("FAIL copy_latency got %0d want 8", n);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (mem[12'h200 + 12'(k)] !== exp[k]) begin
                n_bad++; $display("FAIL copy_dst[%0d] got %h want %h", k, mem[12'h200 + 12'(k)], exp[k]);
            end
            n_cmp++; if (mem[12'h064 + 12'(k)] !== exp[k]) begin
                n_bad++; $display("FAIL copy_src[%0d] got %h want %h", k, mem[12'h064 + 12'(k)], exp[k]);
            end
        end
        n_cmp++; if (mem[12'h203] !== 16'h7777) begin
            n_bad++; $display("FAIL copy_overrun got %h want 7777", mem[12'h203]);
        end
        @(negedge clk);
        n_cmp++; if ({busy, done, bus_req} !== 3'b000) begin
            n_bad++; $display("FAIL copy_idle got %b want 000", {busy, done, bus_req});
        end
    endtask

    task automatic test_fill;
        int n;
        int w0;
        preload(12'h014, 16'h5555);
        w0 = wr_cyc_log.size();
        kick(1'b1, 12'h000, 12'h010, 13'd4, 16'hBEEF);
        wait_done(n);
        n_cmp++; if (n !== 6) begin
            n_bad++; $display("FAIL fill_latency got %0d want 6", n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (mem[12'h010 + 12'(k)] !== 16'hBEEF) begin
                n_bad++; $display("FAIL fill_dst[%0d] got %h want BEEF", k, mem[12'h010 + 12'(k)]);
            end
        end
        n_cmp++; if (mem[12'h014] !== 16'h5555) begin
            n_bad++; $display("FAIL fill_overrun got %h want 5555", mem[12'h014]);
        end
        n_cmp++; if (wr_cyc_log.size() - w0 !== 4) begin
            n_bad++; $display("FAIL fill_write_count got %0d want 4", wr_cyc_log.size() - w0);
        end else begin
            n_cmp++; if (wr_cyc_log[w0 + 3] - wr_cyc_log[w0] !== 3) begin
                n_bad++; $display("FAIL fill_consecutive got span %0d want 3", wr_cyc_log[w0 + 3] - wr_cyc_log[w0]);
            end
        end
    endtask

    task automatic test_grant_stall;
        int n;
        preload(12'h080, 16'h0A0A);
        preload(12'h081, 16'h0B0B);
        kick(1'b0, 12'h080, 12'h0C0, 13'd2, 16'h0000);
        @(posedge clk);          // ARB -> READ
        @(posedge clk);          // READ -> WRITE
        #1 bus_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({memrq, rnw, bus_req, busy} !== 4'b0111) begin
                n_bad++; $display("FAIL stall_ctl[%0d] got %b want 0111", k, {memrq, rnw, bus_req, busy});
            end
            n_cmp++; if (data !== 16'hFFFF) begin
                n_bad++; $display("FAIL stall_data[%0d] got %h want FFFF", k, data);
            end
            @(posedge clk);
        end
        #1 bus_gnt = 1'b1;
        wait_done(n);
        n_cmp++; if (n !== 9) begin
            n_bad++; $display("FAIL stall_latency got %0d want 9", n);
        end
        n_cmp++; if ({mem[12'h0C0], mem[12'h0C1]} !== {16'h0A0A, 16'h0B0B}) begin
            n_bad++; $display("FAIL stall_dst got %h %h want 0A0A 0B0B", mem[12'h0C0], mem[12'h0C1]);
        end
    endtask

    task automatic test_wrap;
        int n;
        int r0;
        logic [11:0] exp_a [4];
        logic [15:0] exp_d [4];
        exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
        exp_d[0] = 16'hA001; exp_d[1] = 16'hA002; exp_d[2] = 16'hA003; exp_d[3] = 16'hA004;
        for (int k = 0; k < 4; k++) preload(exp_a[k], exp_d[k]);
        r0 = rd_log.size();
        kick(1'b0, 12'hFFE, 12'h100, 13'd4, 16'h0000);
        wait_done(n);
        n_cmp++; if (n !== 10) begin
            n_bad++; $display("FAIL wrap_latency got %0d want 10", n);
        end
        n_cmp++; if (rd_log.size() - r0 !== 4) begin
            n_bad++; $display("FAIL wrap_read_count got %0d want 4", rd_log.size() - r0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (rd_log[r0 + k] !== exp_a[k]) begin
                    n_bad++; $display("FAIL wrap_read_addr[%0d] got %h want %h", k, rd_log[r0 + k], exp_a[k]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (mem[12'h100 + 12'(k)] !== exp_d[k]) begin
                n_bad++; $display("FAIL wrap_dst[%0d] got %h want %h", k, mem[12'h100 + 12'(k)], exp_d[k]);
            end
        end
    endtask

    task automatic test_len_zero;
        int n;
        int q0;
        int w0;
        q0 = req_cnt;
        w0 = wr_cyc_log.size();
        kick(1'b1, 12'h000, 12'h020, 13'd0, 16'h9999);
        wait_done(n);
        n_cmp++; if (n !== 1) begin
            n_bad++; $display("FAIL len0_latency got %0d want 1", n);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (req_cnt - q0 !== 0) begin
            n_bad++; $display("FAIL len0_bus_req got %0d cycles want 0", req_cnt - q0);
        end
        n_cmp++; if (wr_cyc_log.size() - w0 !== 0) begin
            n_bad++; $display("FAIL len0_writes got %0d want 0", wr_cyc_log.size() - w0);
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        preload(12'h303, 16'h3333);
        preload(12'h400, 16'h4040);
        kick(1'b1, 12'h000, 12'h300, 13'd3, 16'h1234);
        @(negedge clk);
        mode = 1'b0; src_addr = 12'h500; dst_addr = 12'h400; len = 13'd5; fill_data = 16'hDEAD;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        n_cmp++; if (n !== 5) begin
            n_bad++; $display("FAIL busy_start_latency got %0d want 5", n);
        end
        n_cmp++; if ({mem[12'h300], mem[12'h301], mem[12'h302]} !== {3{16'h1234}}) begin
            n_bad++; $display("FAIL busy_start_dst got %h %h %h want 1234 x3", mem[12'h300], mem[12'h301], mem[12'h302]);
        end
        n_cmp++; if ({mem[12'h303], mem[12'h400]} !== {16'h3333, 16'h4040}) begin
            n_bad++; $display("FAIL busy_start_untouched got %h %h want 3333 4040", mem[12'h303], mem[12'h400]);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, bus_req} !== 2'b00) begin
            n_bad++; $display("FAIL busy_start_restart got %b want 00", {busy, bus_req});
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        for (int k = 0; k < 4; k++) preload(12'h030 + 12'(k), 16'h6600 + 16'(k));
        kick(1'b1, 12'h000, 12'h030, 13'd4, 16'hC0DE);
        @(posedge clk);          // ARB -> WRITE word 0
        @(posedge clk);          // word 1 in progress
        #1 reset = 1'b1;
        d0 = done_cnt;
        @(negedge clk);          // word 1 still commits here
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy, bus_req, memrq, done} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_mid_ctl got %b want 0000", {busy, bus_req, memrq, done});
        end
        n_cmp++; if (data !== 16'hFFFF) begin
            n_bad++; $display("FAIL rst_mid_data got %h want FFFF", data);
        end
        repeat (6) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 0) begin
            n_bad++; $display("FAIL rst_mid_done got %0d pulses want 0", done_cnt - d0);
        end
        n_cmp++; if ({mem[12'h030], mem[12'h031], mem[12'h032], mem[12'h033]} !==
                     {16'hC0DE, 16'hC0DE, 16'h6602, 16'h6603}) begin
            n_bad++; $display("FAIL rst_mid_mem got %h %h %h %h want C0DE C0DE 6602 6603",
                              mem[12'h030], mem[12'h031], mem[12'h032], mem[12'h033]);
        end
    endtask

    initial begin
        test_reset;
        test_copy;
        test_fill;
        test_grant_stall;
        test_wrap;
        test_len_zero;
        test_start_while_busy;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
